// File: rtl/sys_pkg.sv
// sys_pkg: shared types and defaults for the systolic-array output path.
package sys_pkg;
    localparam int DATA_W_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} deskew_state_t;
    typedef logic [2*DATA_W_DEFAULT-1:0] row_vec_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-file FIFO with a registered head; a push when full is
// accepted only if a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr, rd;
    logic         do_push, do_pop;
    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd[AW-1:0]];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop)  rd <= rd + 1'b1;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/sys_out_deskew.sv
// sys_out_deskew: realigns the skewed bottom-row column results into row vectors and
// buffers them for writeback. Optional skew checker: SYS_OUT_DESKEW_SKEW_CHECK_EN.
module sys_out_deskew
    import sys_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid_in,
    input  logic [CNT_W-1:0]    cfg_col_size_in,
    input  logic [CNT_W-1:0]    cfg_row_count_in,
    input  logic [DATA_W-1:0]   col1_data_in,
    input  logic                col1_valid_in,
    input  logic [DATA_W-1:0]   col2_data_in,
    input  logic                col2_valid_in,
    output logic [2*DATA_W-1:0] out_row_data,
    output logic                out_row_valid,
    input  logic                out_row_ready,
    output logic                busy,
    output logic                done,
    output logic                ovf_err
`ifdef SYS_OUT_DESKEW_SKEW_CHECK_EN
    ,
    output logic                skew_err
`endif
);
    deskew_state_t     state, state_nx;
    logic [CNT_W-1:0]  col_size, row_count, rows_seen;
    logic [DATA_W-1:0] hold, col1_part;
    logic              hold_vld, collect, single, cfg_take, row_evt, pop, full, empty;
    logic [2*DATA_W-1:0] row;
    assign collect   = state == COLLECT;
    assign single    = col_size == CNT_W'(1);
    assign cfg_take  = state == IDLE && cfg_valid_in;
    assign row_evt   = collect && (single ? col1_valid_in : col2_valid_in);
    assign col1_part = single ? col1_data_in : (hold_vld ? hold : '0);
    assign row       = {single ? {DATA_W{1'b0}} : col2_data_in, col1_part};
    assign out_row_valid = !empty;
    assign pop       = out_row_valid && out_row_ready;

    sync_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (row_evt),
        .pop   (pop),
        .din   (row),
        .head  (out_row_data),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !cfg_valid_in ? IDLE : (cfg_row_count_in == '0 ? DRAIN : COLLECT);
            COLLECT: state_nx = rows_seen == row_count ? DRAIN : COLLECT;
            DRAIN:   state_nx = empty ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = collect || state == DRAIN;
        done = state == DONE;
    end

    // The hold register only pairs with a column-2 result in the very next cycle.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            col_size  <= CNT_W'(2);
            row_count <= '0;
            rows_seen <= '0;
            hold      <= '0;
            hold_vld  <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (cfg_take) begin
                col_size  <= cfg_col_size_in;
                row_count <= cfg_row_count_in;
            end
            if (cfg_take)                                  rows_seen <= '0;
            else if (row_evt && rows_seen != row_count)    rows_seen <= rows_seen + 1'b1;
            if (col1_valid_in) hold <= col1_data_in;
            hold_vld <= collect && !single && col1_valid_in;
            ovf_err  <= ovf_err || (row_evt && full && !pop);
        end

`ifdef SYS_OUT_DESKEW_SKEW_CHECK_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) skew_err <= 1'b0;
        else     skew_err <= skew_err || (collect && !single && (hold_vld != col2_valid_in));
`endif
endmodule

// File: tb/tb_sys_out_deskew.sv
// tb_sys_out_deskew: directed table-driven bench for sys_out_deskew plus
// hand-written overflow, reset and skew-check sequences.
module tb_sys_out_deskew;
    import sys_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cfg_valid_in = 1'b0;
    logic [15:0] cfg_col_size_in = '0, cfg_row_count_in = '0;
    logic [15:0] col1_data_in = '0, col2_data_in = '0;
    logic        col1_valid_in = 1'b0, col2_valid_in = 1'b0;
    logic [31:0] out_row_data;
    logic        out_row_valid, out_row_ready = 1'b1;
    logic        busy, done, ovf_err;
`ifdef SYS_OUT_DESKEW_SKEW_CHECK_EN
    logic        skew_err;
`endif

    sys_out_deskew dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid_in     (cfg_valid_in),
        .cfg_col_size_in  (cfg_col_size_in),
        .cfg_row_count_in (cfg_row_count_in),
        .col1_data_in     (col1_data_in),
        .col1_valid_in    (col1_valid_in),
        .col2_data_in     (col2_data_in),
        .col2_valid_in    (col2_valid_in),
        .out_row_data     (out_row_data),
        .out_row_valid    (out_row_valid),
        .out_row_ready    (out_row_ready),
        .busy             (busy),
        .done             (done),
        .ovf_err          (ovf_err)
`ifdef SYS_OUT_DESKEW_SKEW_CHECK_EN
        ,
        .skew_err         (skew_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg;
        logic [15:0] size, rows;
        logic        c1v;
        logic [15:0] c1d;
        logic        c2v;
        logic [15:0] c2d;
        logic        rdy;
        logic        e_valid;
        row_vec_t    e_data;
        logic        e_busy, e_done, e_ovf;
    } vec_t;

    localparam int NV = 18;
    vec_t tv [NV];
    int checks = 0, errors = 0;
    logic got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_valid_in  = 1'b0;
        col1_valid_in = 1'b0;
        col2_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            step();
            got = done;
        end
        chk(name, {31'b0, got}, 32'd1);
        step();
    endtask

    initial begin
        tv = '{
            // col_size=2, rows=3; a cfg pulse mid-job must be ignored
            '{1, 2, 3, 0, 0,     0, 0,     1, 0, 0,          1, 0, 0},
            '{0, 0, 0, 1, 'h11,  0, 0,     1, 0, 0,          1, 0, 0},
            '{1, 1, 9, 1, 'h22,  1, 'h101, 1, 1, 'h01010011, 1, 0, 0},
            '{0, 0, 0, 1, 'h33,  1, 'h202, 1, 1, 'h02020022, 1, 0, 0},
            '{0, 0, 0, 0, 0,     1, 'h303, 1, 1, 'h03030033, 1, 0, 0},
            '{0, 0, 0, 0, 0,     0, 0,     1, 0, 0,          1, 0, 0},
            '{0, 0, 0, 0, 0,     0, 0,     1, 0, 0,          0, 1, 0},
            '{0, 0, 0, 0, 0,     0, 0,     1, 0, 0,          0, 0, 0},
            // col_size=1, rows=2; col2 ignored, inputs outside COLLECT ignored
            '{1, 1, 2, 0, 0,     0, 0,      1, 0, 0,         1, 0, 0},
            '{0, 0, 0, 1, 'hAA,  1, 'h5555, 1, 1, 'h000000AA, 1, 0, 0},
            '{0, 0, 0, 1, 'hBB,  1, 'h7777, 1, 1, 'h000000BB, 1, 0, 0},
            '{0, 0, 0, 0, 0,     1, 'h1234, 1, 0, 0,         1, 0, 0},
            '{0, 0, 0, 0, 0,     0, 0,      1, 0, 0,         0, 1, 0},
            '{0, 0, 0, 1, 'hEE,  1, 'hEE,   1, 0, 0,         0, 0, 0},
            '{0, 0, 0, 0, 0,     0, 0,      1, 0, 0,         0, 0, 0},
            // rows=0: DRAIN then DONE two cycles after cfg
            '{1, 2, 0, 0, 0,     0, 0,      1, 0, 0,         1, 0, 0},
            '{0, 0, 0, 0, 0,     0, 0,      1, 0, 0,         0, 1, 0},
            '{0, 0, 0, 0, 0,     0, 0,      1, 0, 0,         0, 0, 0}
        };

        step();
        step();
        chk("rst_valid", {31'b0, out_row_valid}, 32'd0);
        chk("rst_data", out_row_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cfg_valid_in     = tv[i].cfg;
            cfg_col_size_in  = tv[i].size;
            cfg_row_count_in = tv[i].rows;
            col1_valid_in    = tv[i].c1v;
            col1_data_in     = tv[i].c1d;
            col2_valid_in    = tv[i].c2v;
            col2_data_in     = tv[i].c2d;
            out_row_ready    = tv[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, out_row_valid}, {31'b0, tv[i].e_valid});
            if (tv[i].e_valid) chk($sformatf("v%0d_data", i), out_row_data, tv[i].e_data);
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tv[i].e_busy});
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, tv[i].e_done});
            chk($sformatf("v%0d_ovf", i), {31'b0, ovf_err}, {31'b0, tv[i].e_ovf});
        end
        idle_in();

        // Overflow: 6 back-to-back rows into a 4-deep FIFO with the consumer stalled
        out_row_ready    = 1'b0;
        cfg_valid_in     = 1'b1;
        cfg_col_size_in  = 16'd2;
        cfg_row_count_in = 16'd6;
        step();
        cfg_valid_in = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            col1_valid_in = k < 6;
            col1_data_in  = 16'(k + 1);
            col2_valid_in = k >= 1;
            col2_data_in  = 16'h0100 + 16'(k);
            step();
        end
        idle_in();
        chk("ovf_flag", {31'b0, ovf_err}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("ovf_hold_busy", {31'b0, busy}, 32'd1);
            chk("ovf_hold_done", {31'b0, done}, 32'd0);
            step();
        end
        out_row_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("ovf_row%0d_valid", j), {31'b0, out_row_valid}, 32'd1);
            chk($sformatf("ovf_row%0d_data", j), out_row_data, {16'h0100 + 16'(j), 16'(j)});
            step();
        end
        chk("ovf_empty", {31'b0, out_row_valid}, 32'd0);
        wait_done("ovf_done");
        chk("ovf_sticky", {31'b0, ovf_err}, 32'd1);

        // Asynchronous reset mid-job with two rows buffered
        out_row_ready    = 1'b0;
        cfg_valid_in     = 1'b1;
        cfg_col_size_in  = 16'd2;
        cfg_row_count_in = 16'd5;
        step();
        cfg_valid_in = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            col1_valid_in = k < 2;
            col1_data_in  = 16'h0A0 + 16'(k);
            col2_valid_in = k >= 1;
            col2_data_in  = 16'h0B0 + 16'(k);
            step();
        end
        idle_in();
        chk("mid_valid", {31'b0, out_row_valid}, 32'd1);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_row_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_ovf", {31'b0, ovf_err}, 32'd0);
        step();
        rst = 1'b0;
        out_row_ready    = 1'b1;
        cfg_valid_in     = 1'b1;
        cfg_col_size_in  = 16'd1;
        cfg_row_count_in = 16'd1;
        step();
        cfg_valid_in  = 1'b0;
        col1_valid_in = 1'b1;
        col1_data_in  = 16'h00CC;
        step();
        idle_in();
        chk("post_rst_valid", {31'b0, out_row_valid}, 32'd1);
        chk("post_rst_data", out_row_data, 32'h000000CC);
        wait_done("post_rst_done");

`ifdef SYS_OUT_DESKEW_SKEW_CHECK_EN
        cfg_valid_in     = 1'b1;
        cfg_col_size_in  = 16'd2;
        cfg_row_count_in = 16'd2;
        step();
        cfg_valid_in  = 1'b0;
        col1_valid_in = 1'b1;
        col1_data_in  = 16'h0055;
        step();
        col1_valid_in = 1'b0;
        chk("skew_t1", {31'b0, skew_err}, 32'd0);
        step();
        chk("skew_t2", {31'b0, skew_err}, 32'd1);
        step();
        chk("skew_sticky", {31'b0, skew_err}, 32'd1);
        rst = 1'b1;
        #1;
        chk("skew_rst", {31'b0, skew_err}, 32'd0);
        step();
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
